ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have port: sys_clk  input  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL have port: sys_resetn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: m0_valid in 1, m0_addr in 13 (byte address), m0_wdata in 32, m0_wstrb in 4, m0_ready out 1, m0_rdata out 32; master 0 is the CPU.
REQ-004 SHALL have ports: m1_valid in 1, m1_addr in 13, m1_wdata in 32, m1_wstrb in 4, m1_ready out 1, m1_rdata out 32; master 1 is the DMA.
REQ-005 SHALL have RAM-side ports: ram_address out 11 (word), ram_byteena out 4, ram_data out 32, ram_rden out 1, ram_wren out 1, ram_q in 32. ram_q is valid one clock after the rden cycle.
REQ-006 SHALL have port: grant_owner  output  1  index of the master currently being served (debug).

Function
REQ-007 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-008 IDLE: if any valid is high at the edge, latch the winner's addr[12:2], wdata and wstrb plus its index, then go to ACCESS; otherwise stay in IDLE.
REQ-009 ACCESS (one cycle): drive ram_address, ram_byteena and ram_data from the latched request; ram_wren=1 if latched wstrb!=0, else ram_rden=1; byteena=wstrb for writes, 4'hF for reads; next state DONE.
REQ-010 DONE (one cycle): assert ready of the granted master only; rdata of the granted master = ram_q (reads), unchanged (writes); next state IDLE.
REQ-011 Latency: valid sampled at edge k gives ready high during cycle k+2; back-to-back service period 3 cycles.
REQ-012 ready SHALL be a single-cycle pulse; the non-granted master's ready SHALL stay 0.
REQ-013 Masters SHALL hold valid, addr, wdata and wstrb stable until ready. The arbiter uses only the copy latched at grant, so changes after the grant do not corrupt the access.
REQ-014 ram_rden and ram_wren SHALL be 0 outside ACCESS and never both 1.
REQ-015 Simultaneous valid in IDLE: the winner follows REQ-021. The loser keeps valid high and is granted in the next IDLE, 3 cycles later, unless it loses again under fixed priority.
REQ-016 The ready edge plus one IDLE cycle SHALL give the master time to drop valid before re-arbitration. No master is re-served on a stale valid.
REQ-017 m*_rdata SHALL be registered and held until that master's next read completes.

Reset
REQ-018 Asserting sys_resetn low SHALL immediately force: state IDLE, m0_ready=m1_ready=0, ram_rden=ram_wren=0, m0_rdata=m1_rdata=0, grant_owner=0, last-grant pointer=1.
REQ-019 Reset during ACCESS or DONE SHALL abort the transfer with no ready pulse. The first edge after release is evaluated as IDLE.

Configuration
REQ-020 Macro RAM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy at compile time.
REQ-021 Defined: round-robin; on a tie, grant the master not granted last (pointer updated at each grant; after reset m0 wins the first tie). Undefined: fixed priority, m0 always wins ties, no pointer register.

Verification
REQ-022 Single write: m0 write addr 0x0010, wdata 0xDEADBEEF, wstrb 4'hF -> ram_wren=1 with ram_address=0x004 one cycle after valid; m0_ready pulse on the following cycle.
REQ-023 Read-back: m1 read addr 0x0010 -> ram_rden=1 and ram_byteena=4'hF in ACCESS; m1_rdata=0xDEADBEEF with m1_ready in DONE; m0_ready stays 0.
REQ-024 Byte write: m0 write addr 0x0013, wstrb 4'b1000, wdata 0x55000000, then a read -> returns 0x55ADBEEF.
REQ-025 Tie: both valid held for 12 cycles -> with macro defined, grants alternate m0,m1,m0,m1 (period 3 cycles); with macro undefined, only m0 is served while its valid stays high.
REQ-026 Reset mid-op: assert sys_resetn low during ACCESS of a write -> ready stays 0, wren drops asynchronously; after release, an idle bus yields no spurious ready.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between two masters, the CPU (m0)
// and the DMA (m1). Each grant takes IDLE -> ACCESS -> DONE, so one request
// is served every 3 cycles. The request is copied at grant time, so a master
// that changes its bus after the grant cannot corrupt the access.
// Compile-time option RAM_ARB_ROUND_ROBIN_EN: when defined, ties go to the
// master not served last; when undefined, m0 always wins ties.
module ram_arbiter (
  input  logic        sys_clk,
  input  logic        sys_resetn,
  // master 0 (CPU)
  input  logic        m0_valid,
  input  logic [12:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  // master 1 (DMA)
  input  logic        m1_valid,
  input  logic [12:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  // RAM side (word addressed, read data one clock after rden)
  output logic [10:0] ram_address,
  output logic [3:0]  ram_byteena,
  output logic [31:0] ram_data,
  output logic        ram_rden,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  // debug
  output logic        grant_owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_reg, state_next;
  logic [10:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;
  logic        owner_reg;
  logic [31:0] rdata0_reg;
  logic [31:0] rdata1_reg;
  logic        any_valid;
  logic        winner;
  logic        is_write;
  logic        done_read;
  logic        grant_now;

  // Byte-lane bits of the addresses do not reach the word-addressed RAM.
  logic        unused_addr_lsbs;
  assign unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

  assign any_valid = m0_valid | m1_valid;
  assign grant_now = (state_reg == IDLE) && any_valid;
  assign is_write  = (wstrb_reg != 4'h0);
  assign done_read = (state_reg == DONE) && !is_write;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last_grant_reg;

  // Round-robin pick: on a tie the master not served last wins.
  always_comb begin
    winner = 1'b0;
    if (m0_valid && m1_valid) winner = ~last_grant_reg;
    else if (m1_valid)        winner = 1'b1;
  end

  // Remember the last grant; reset value 1 lets m0 win the first tie.
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn)    last_grant_reg <= 1'b1;
    else if (grant_now) last_grant_reg <= winner;
  end
`else
  // Fixed priority pick: m1 only wins when m0 is not requesting.
  always_comb begin
    winner = 1'b0;
    if (!m0_valid && m1_valid) winner = 1'b1;
  end
`endif

  // State register plus the request copy taken at grant time.
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_reg <= IDLE;
      addr_reg  <= 11'h000;
      wdata_reg <= 32'h0;
      wstrb_reg <= 4'h0;
      owner_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_now) begin
        owner_reg <= winner;
        if (winner) begin
          addr_reg  <= m1_addr[12:2];
          wdata_reg <= m1_wdata;
          wstrb_reg <= m1_wstrb;
        end else begin
          addr_reg  <= m0_addr[12:2];
          wdata_reg <= m0_wdata;
          wstrb_reg <= m0_wstrb;
        end
      end
    end
  end

  // Read data registers: capture RAM output at the end of a read's DONE cycle.
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      rdata0_reg <= 32'h0;
      rdata1_reg <= 32'h0;
    end else if (done_read) begin
      if (owner_reg) rdata1_reg <= ram_q;
      else           rdata0_reg <= ram_q;
    end
  end

  // Next state and RAM / ready strobes decoded from the current state.
  always_comb begin
    state_next  = state_reg;
    ram_address = addr_reg;
    ram_data    = wdata_reg;
    ram_byteena = 4'h0;
    ram_rden    = 1'b0;
    ram_wren    = 1'b0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_valid) state_next = ACCESS;
      end
      ACCESS: begin
        if (is_write) begin
          ram_wren    = 1'b1;
          ram_byteena = wstrb_reg;
        end else begin
          ram_rden    = 1'b1;
          ram_byteena = 4'hF;
        end
        state_next = DONE;
      end
      DONE: begin
        m0_ready   = ~owner_reg;
        m1_ready   = owner_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // During a read's DONE cycle the fresh RAM word is passed straight through
  // so it is valid alongside ready; afterwards the captured copy is held.
  assign m0_rdata    = (done_read && !owner_reg) ? ram_q : rdata0_reg;
  assign m1_rdata    = (done_read &&  owner_reg) ? ram_q : rdata1_reg;
  assign grant_owner = owner_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed tests for ram_arbiter with a byte-enabled RAM
// model. Expected values are hand-computed constants.
module tb_ram_arbiter;
  logic        sys_clk;
  logic        sys_resetn;
  logic        m0_valid, m1_valid;
  logic [12:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [10:0] ram_address;
  logic [3:0]  ram_byteena;
  logic [31:0] ram_data;
  logic        ram_rden, ram_wren;
  logic [31:0] ram_q;
  logic        grant_owner;
  logic        mem_clear;
  logic [31:0] mem [0:2047];

  int errors;
  int checks;

  ram_arbiter dut (
    .sys_clk(sys_clk), .sys_resetn(sys_resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .ram_address(ram_address), .ram_byteena(ram_byteena), .ram_data(ram_data),
    .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_q(ram_q),
    .grant_owner(grant_owner)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Single-port RAM model: byte-enabled write, registered read.
  always @(posedge sys_clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
    end else begin
      if (ram_wren)
        for (int b = 0; b < 4; b++)
          if (ram_byteena[b]) mem[ram_address][b*8 +: 8] <= ram_data[b*8 +: 8];
      if (ram_rden) ram_q <= mem[ram_address];
    end
  end

  task automatic drive_m(input int m, input logic v, input logic [12:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    if (m == 0) begin
      m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s;
    end else begin
      m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
    end
  endtask

  task automatic test_reset;
    sys_resetn = 1'b0;
    mem_clear  = 1'b1;
    ram_q      = 32'h0;
    drive_m(0, 1'b0, 13'h0, 32'h0, 4'h0);
    drive_m(1, 1'b0, 13'h0, 32'h0, 4'h0);
    repeat (3) @(posedge sys_clk);
    #1;
    checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL rst_m0_ready: got %b expected 0", m0_ready); end
    checks++; if (m1_ready !== 1'b0) begin errors++; $display("FAIL rst_m1_ready: got %b expected 0", m1_ready); end
    checks++; if (ram_rden !== 1'b0) begin errors++; $display("FAIL rst_rden: got %b expected 0", ram_rden); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b expected 0", ram_wren); end
    checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL rst_m0_rdata: got %h expected 0", m0_rdata); end
    checks++; if (m1_rdata !== 32'h0) begin errors++; $display("FAIL rst_m1_rdata: got %h expected 0", m1_rdata); end
    checks++; if (grant_owner !== 1'b0) begin errors++; $display("FAIL rst_owner: got %b expected 0", grant_owner); end
    mem_clear = 1'b0;
    #3 sys_resetn = 1'b1;
    repeat (2) begin
      @(posedge sys_clk); #1;
      checks++; if ((m0_ready | m1_ready | ram_rden | ram_wren) !== 1'b0) begin
        errors++; $display("FAIL rst_idle_quiet: got ready=%b%b rden=%b wren=%b expected all 0",
                           m0_ready, m1_ready, ram_rden, ram_wren);
      end
    end
    $display("txn reset done");
  endtask

  task automatic test_single_write;
    @(posedge sys_clk); #1;
    drive_m(0, 1'b1, 13'h0010, 32'hDEADBEEF, 4'hF);
    @(posedge sys_clk); #1;   // ACCESS
    checks++; if (ram_wren !== 1'b1) begin errors++; $display("FAIL wr_wren: got %b expected 1", ram_wren); end
    checks++; if (ram_rden !== 1'b0) begin errors++; $display("FAIL wr_rden: got %b expected 0", ram_rden); end
    checks++; if (ram_address !== 11'h004) begin errors++; $display("FAIL wr_addr: got %h expected 004", ram_address); end
    checks++; if (ram_byteena !== 4'hF) begin errors++; $display("FAIL wr_byteena: got %h expected F", ram_byteena); end
    checks++; if (ram_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data: got %h expected deadbeef", ram_data); end
    checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL wr_early_ready: got %b expected 0", m0_ready); end
    @(posedge sys_clk); #1;   // DONE
    checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL wr_m0_ready: got %b expected 1", m0_ready); end
    checks++; if (m1_ready !== 1'b0) begin errors++; $display("FAIL wr_m1_ready: got %b expected 0", m1_ready); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL wr_wren_done: got %b expected 0", ram_wren); end
    checks++; if (grant_owner !== 1'b0) begin errors++; $display("FAIL wr_owner: got %b expected 0", grant_owner); end
    drive_m(0, 1'b0, 13'h0, 32'h0, 4'h0);
    @(posedge sys_clk); #1;   // IDLE
    checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_pulse: got %b expected 0", m0_ready); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem: got %h expected deadbeef", mem[4]); end
    $display("txn m0 write addr=0010 data=deadbeef strb=f");
  endtask

  task automatic test_read_back;
    @(posedge sys_clk); #1;
    drive_m(1, 1'b1, 13'h0010, 32'h0, 4'h0);
    @(posedge sys_clk); #1;   // ACCESS
    checks++; if (ram_rden !== 1'b1) begin errors++; $display("FAIL rd_rden: got %b expected 1", ram_rden); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL rd_wren: got %b expected 0", ram_wren); end
    checks++; if (ram_byteena !== 4'hF) begin errors++; $display("FAIL rd_byteena: got %h expected F", ram_byteena); end
    checks++; if (ram_address !== 11'h004) begin errors++; $display("FAIL rd_addr: got %h expected 004", ram_address); end
    checks++; if (grant_owner !== 1'b1) begin errors++; $display("FAIL rd_owner: got %b expected 1", grant_owner); end
    @(posedge sys_clk); #1;   // DONE
    checks++; if (m1_ready !== 1'b1) begin errors++; $display("FAIL rd_m1_ready: got %b expected 1", m1_ready); end
    checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL rd_m0_ready: got %b expected 0", m0_ready); end
    checks++; if (m1_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_m1_rdata: got %h expected deadbeef", m1_rdata); end
    checks++; if (ram_rden !== 1'b0) begin errors++; $display("FAIL rd_rden_done: got %b expected 0", ram_rden); end
    drive_m(1, 1'b0, 13'h0, 32'h0, 4'h0);
    @(posedge sys_clk); #1;   // IDLE
    checks++; if (m1_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_pulse: got %b expected 0", m1_ready); end
    checks++; if (m1_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_m1_hold: got %h expected deadbeef", m1_rdata); end
    checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL rd_m0_untouched: got %h expected 0", m0_rdata); end
    $display("txn m1 read addr=0010 data=%h", m1_rdata);
  endtask

  task automatic test_byte_write;
    @(posedge sys_clk); #1;
    drive_m(0, 1'b1, 13'h0013, 32'h55000000, 4'b1000);
    @(posedge sys_clk); #1;   // ACCESS
    checks++; if (ram_byteena !== 4'b1000) begin errors++; $display("FAIL bw_byteena: got %b expected 1000", ram_byteena); end
    checks++; if (ram_address !== 11'h004) begin errors++; $display("FAIL bw_addr: got %h expected 004", ram_address); end
    @(posedge sys_clk); #1;   // DONE
    checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL bw_ready: got %b expected 1", m0_ready); end
    // switch straight to a read; the next IDLE edge samples it
    drive_m(0, 1'b1, 13'h0010, 32'h0, 4'h0);
    @(posedge sys_clk); #1;   // IDLE
    checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL bw_idle_ready: got %b expected 0", m0_ready); end
    $display("txn m0 write addr=0013 data=55000000 strb=8");
    @(posedge sys_clk); #1;   // ACCESS
    checks++; if (ram_rden !== 1'b1) begin errors++; $display("FAIL bw_rd_rden: got %b expected 1", ram_rden); end
    @(posedge sys_clk); #1;   // DONE
    checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL bw_rd_ready: got %b expected 1", m0_ready); end
    checks++; if (m0_rdata !== 32'h55ADBEEF) begin errors++; $display("FAIL bw_rd_data: got %h expected 55adbeef", m0_rdata); end
    drive_m(0, 1'b0, 13'h0, 32'h0, 4'h0);
    @(posedge sys_clk); #1;   // IDLE
    checks++; if (m0_rdata !== 32'h55ADBEEF) begin errors++; $display("FAIL bw_m0_hold: got %h expected 55adbeef", m0_rdata); end
    checks++; if (m1_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL bw_m1_hold: got %h expected deadbeef", m1_rdata); end
    $display("txn m0 read addr=0010 data=%h", m0_rdata);
  endtask

  task automatic test_tie;
    int g [4];
    int exp_g [4];
    int n;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    g = '{-1, -1, -1, -1};
    n = 0;
    // fresh reset so the round-robin pointer starts from its reset value
    @(posedge sys_clk); #3;
    sys_resetn = 1'b0;
    #4 sys_resetn = 1'b1;
    @(posedge sys_clk); #1;
    drive_m(0, 1'b1, 13'h0010, 32'h0, 4'h0);
    drive_m(1, 1'b1, 13'h0000, 32'h0, 4'h0);
    for (int c = 0; c < 12; c++) begin
      @(posedge sys_clk); #1;
      checks++; if ((m0_ready & m1_ready) !== 1'b0 || (ram_rden & ram_wren) !== 1'b0) begin
        errors++; $display("FAIL tie_exclusive: cycle %0d got ready=%b%b rden=%b wren=%b expected no overlap",
                           c, m0_ready, m1_ready, ram_rden, ram_wren);
      end
      if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
        if (n < 4) g[n] = (m1_ready === 1'b1) ? 1 : 0;
        n++;
      end
    end
    drive_m(0, 1'b0, 13'h0, 32'h0, 4'h0);
    drive_m(1, 1'b0, 13'h0, 32'h0, 4'h0);
    checks++; if (n !== 4) begin errors++; $display("FAIL tie_count: got %0d grants expected 4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (g[i] !== exp_g[i]) begin
        errors++; $display("FAIL tie_grant%0d: got m%0d expected m%0d", i, g[i], exp_g[i]);
      end
      $display("txn tie grant %0d -> m%0d", i, g[i]);
    end
    repeat (3) @(posedge sys_clk);
  endtask

  task automatic test_reset_mid_op;
    @(posedge sys_clk); #1;
    drive_m(0, 1'b1, 13'h0020, 32'h22222222, 4'hF);
    @(posedge sys_clk); #1;   // ACCESS
    checks++; if (ram_wren !== 1'b1) begin errors++; $display("FAIL mid_wren_pre: got %b expected 1", ram_wren); end
    #2 sys_resetn = 1'b0;
    #1;
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL mid_wren_async: got %b expected 0", ram_wren); end
    checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b expected 0", m0_ready); end
    checks++; if (grant_owner !== 1'b0) begin errors++; $display("FAIL mid_owner: got %b expected 0", grant_owner); end
    drive_m(0, 1'b0, 13'h0, 32'h0, 4'h0);
    @(posedge sys_clk); #1;
    checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_rst: got %b expected 0", m0_ready); end
    #2 sys_resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge sys_clk); #1;
      checks++; if ((m0_ready | m1_ready | ram_rden | ram_wren) !== 1'b0) begin
        errors++; $display("FAIL mid_spurious: cycle %0d got ready=%b%b rden=%b wren=%b expected all 0",
                           c, m0_ready, m1_ready, ram_rden, ram_wren);
      end
    end
    $display("txn m0 write addr=0020 aborted by reset");
    // the aborted word must still read back as its cleared value
    drive_m(0, 1'b1, 13'h0020, 32'h0, 4'h0);
    repeat (2) @(posedge sys_clk);
    #1;
    checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL mid_rd_ready: got %b expected 1", m0_ready); end
    checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL mid_rd_data: got %h expected 0", m0_rdata); end
    drive_m(0, 1'b0, 13'h0, 32'h0, 4'h0);
    @(posedge sys_clk); #1;
    $display("txn m0 read addr=0020 data=%h", m0_rdata);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_write();
    test_read_back();
    test_byte_write();
    test_tie();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so a stuck run still ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
